sram_arbiter: RTL and testbench

Parametrised N-channel arbiter that multiplexes the fetch and memory pipeline stages, plus optional DMA/UART channels, onto one asynchronous external SRAM bank (BaseRAM or ExtRAM). It accepts one request at a time, selecting among channels by either fixed or round-robin priority. It sequences the SRAM strobes with a configurable number of wait states and returns read data with a per-channel completion pulse. One instance sits between the pipeline and each SRAM bank; the top level owns the tristate buffer.

---
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// N-channel arbiter sharing one asynchronous SRAM bank; fixed or round-robin grant,
// registered strobes with WAIT_CYCLES extra strobe cycles and a per-channel completion pulse.
//
// state  | meaning
// IDLE   | waiting for a request; grant is combinational and accepted this cycle
// ACCESS | strobes asserted, wait counter running down to zero
// DONE   | strobes released, write data still driven, resp_valid pulses
module sram_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W/8-1:0]        ram_be_n,
    output logic                       ram_ce_n,
    output logic                       ram_oe_n,
    output logic                       ram_we_n,
    output logic [DATA_W-1:0]          ram_data_o,
    output logic                       ram_data_oe,
    input  logic [DATA_W-1:0]          ram_data_i
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gnt_q, last_q, gnt_idx;
    logic              gnt_any;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [BE_W-1:0]   ram_be_n_q;
    logic              ram_ce_n_q, ram_oe_n_q, ram_we_n_q, ram_data_oe_q;
    logic [DATA_W-1:0] ram_data_q;

    logic              sel_we;
    logic [BE_W-1:0]   sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Search starts just past the last grant in round-robin, at channel 0 otherwise.
    always_comb begin
        int base;
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        base    = (RR_MODE != 0) ? int'(last_q) + 1 : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (base + k) % NUM_CH;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = GW'(idx);
            end
        end
    end

    assign sel_we    = req_we[gnt_idx];
    assign sel_be    = req_be[int'(gnt_idx)*BE_W +: BE_W];
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            last_q        <= GW'(NUM_CH - 1);
            we_q          <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            ram_addr_q    <= '0;
            ram_be_n_q    <= '1;
            ram_ce_n_q    <= 1'b1;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            ram_data_q    <= '0;
            ram_data_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        gnt_q         <= gnt_idx;
                        last_q        <= gnt_idx;
                        we_q          <= sel_we;
                        cnt_q         <= 4'(WAIT_CYCLES);
                        ram_addr_q    <= sel_addr;
                        ram_be_n_q    <= ~sel_be;
                        ram_ce_n_q    <= 1'b0;
                        ram_oe_n_q    <= sel_we;
                        ram_we_n_q    <= ~sel_we;
                        ram_data_oe_q <= sel_we;
                        if (sel_we) begin
                            ram_data_q <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            rdata_q <= ram_data_i;
                        end
                        ram_ce_n_q <= 1'b1;
                        ram_oe_n_q <= 1'b1;
                        ram_we_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    ram_data_oe_q <= 1'b0;
                    ram_be_n_q    <= '1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == IDLE && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
        if (state_q == DONE) begin
            resp_valid[gnt_q] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    assign resp_rdata  = rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_be_n    = ram_be_n_q;
    assign ram_ce_n    = ram_ce_n_q;
    assign ram_oe_n    = ram_oe_n_q;
    assign ram_we_n    = ram_we_n_q;
    assign ram_data_o  = ram_data_q;
    assign ram_data_oe = ram_data_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance A (2 ch, 1 wait, fixed) and instance B (3 ch, 0 wait, round-robin),
// each with a behavioural SRAM, a shadow memory and a response scoreboard.
module tb_sram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [2:0]  vld [2];
    logic [2:0]  we  [2];
    logic [11:0] be  [2];
    logic [59:0] ad  [2];
    logic [95:0] wd  [2];

    logic [1:0]  rdy_a, rv_a;
    logic [31:0] rd_a, do_a, di_a;
    logic        busy_a, ce_a, oe_a, wen_a, doe_a;
    logic [19:0] addr_a;
    logic [3:0]  ben_a;

    logic [2:0]  rdy_b, rv_b;
    logic [31:0] rd_b, do_b, di_b;
    logic        busy_b, ce_b, oe_b, wen_b, doe_b;
    logic [19:0] addr_b;
    logic [3:0]  ben_b;

    sram_arbiter #(.NUM_CH(2), .ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1), .RR_MODE(0)) u_a (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0][1:0]), .req_we(we[0][1:0]),
        .req_be(be[0][7:0]), .req_addr(ad[0][39:0]), .req_wdata(wd[0][63:0]),
        .req_ready(rdy_a), .resp_valid(rv_a), .resp_rdata(rd_a), .busy(busy_a),
        .ram_addr(addr_a), .ram_be_n(ben_a), .ram_ce_n(ce_a), .ram_oe_n(oe_a), .ram_we_n(wen_a),
        .ram_data_o(do_a), .ram_data_oe(doe_a), .ram_data_i(di_a));

    sram_arbiter #(.NUM_CH(3), .ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0), .RR_MODE(1)) u_b (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_we(we[1]),
        .req_be(be[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .req_ready(rdy_b), .resp_valid(rv_b), .resp_rdata(rd_b), .busy(busy_b),
        .ram_addr(addr_b), .ram_be_n(ben_b), .ram_ce_n(ce_b), .ram_oe_n(oe_b), .ram_we_n(wen_b),
        .ram_data_o(do_b), .ram_data_oe(doe_b), .ram_data_i(di_b));

    logic [2:0]  rdy_x [2];
    logic [2:0]  rv_x  [2];
    logic [31:0] rd_x  [2];
    assign rdy_x[0] = {1'b0, rdy_a};
    assign rdy_x[1] = rdy_b;
    assign rv_x[0]  = {1'b0, rv_a};
    assign rv_x[1]  = rv_b;
    assign rd_x[0]  = rd_a;
    assign rd_x[1]  = rd_b;

    // Behavioural asynchronous SRAMs; an undriven read returns a marker value.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    assign di_a = (!ce_a && !oe_a) ? mem_a[addr_a[7:0]] : 32'h0BAD0BAD;
    assign di_b = (!ce_b && !oe_b) ? mem_b[addr_b[7:0]] : 32'h0BAD0BAD;
    always @(posedge clk) begin
        if (!ce_a && !wen_a)
            for (int i = 0; i < 4; i++) if (!ben_a[i]) mem_a[addr_a[7:0]][i*8 +: 8] <= do_a[i*8 +: 8];
    end
    always @(posedge clk) begin
        if (!ce_b && !wen_b)
            for (int i = 0; i < 4; i++) if (!ben_b[i]) mem_b[addr_b[7:0]][i*8 +: 8] <= do_b[i*8 +: 8];
    end

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        int          ch;
        logic        we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    exp_t        qa[$], qb[$];
    int          gla[$], glb[$], aca[$], acb[$];
    logic [31:0] shadow [2][256];
    int          next_ok [2];
    int          last_g  [2];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;

    function automatic int nch(input int d); return (d == 0) ? 2 : 3; endfunction
    function automatic int wt(input int d);  return (d == 0) ? 1 : 0; endfunction
    function automatic bit rr(input int d);  return d == 1;           endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic int qsize(input int d); return (d == 0) ? qa.size() : qb.size(); endfunction
    function automatic int gsize(input int d); return (d == 0) ? gla.size() : glb.size(); endfunction

    function automatic int pick(input int d);
        int n, s, c;
        n = nch(d);
        s = rr(d) ? (last_g[d] + 1) % n : 0;
        for (int k = 0; k < n; k++) begin
            c = (s + k) % n;
            if (vld[d][c]) return c;
        end
        return -1;
    endfunction

    // Called mid-cycle: predict the grant, compare req_ready, and queue the expected response.
    task automatic sample(input int d);
        logic [2:0] er;
        int         g, obs;
        logic [7:0] a8;
        exp_t       e;
        er = '0;
        g  = -1;
        if (!rst[d] && cyc_n >= next_ok[d]) g = pick(d);
        if (g >= 0) er[g] = 1'b1;
        chk((d == 0) ? "ready_a" : "ready_b", rdy_x[d], er);
        obs = -1;
        for (int i = 0; i < 3; i++) if (rdy_x[d] == (3'b001 << i)) obs = i;
        if (obs >= 0) begin
            if (d == 0) begin gla.push_back(obs); aca.push_back(cyc_n); end
            else        begin glb.push_back(obs); acb.push_back(cyc_n); end
        end
        if (g >= 0) begin
            a8      = ad[d][g*20 +: 8];
            e.ch    = g;
            e.we    = we[d][g];
            e.due   = cyc_n + 2 + wt(d);
            e.rdata = shadow[d][a8];
            if (e.we)
                for (int i = 0; i < 4; i++)
                    if (be[d][g*4 + i]) shadow[d][a8][i*8 +: 8] = wd[d][g*32 + i*8 +: 8];
            if (d == 0) qa.push_back(e); else qb.push_back(e);
            next_ok[d] = cyc_n + 3 + wt(d);
            last_g[d]  = g;
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (rv_x[d] != 3'b000) begin
            if (qsize(d) == 0) begin
                chk("resp_unexpected", rv_x[d], 0);
            end else begin
                if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
                chk("resp_ch", rv_x[d], 3'b001 << e.ch);
                chk("resp_cycle", cyc_n, e.due);
                if (!e.we) begin
                    chk("resp_rdata", rd_x[d], e.rdata);
                    last_rd[d] = rd_x[d];
                end
            end
        end else if (qsize(d) != 0) begin
            e = (d == 0) ? qa[0] : qb[0];
            if (e.due <= cyc_n) begin
                chk("resp_missing", rv_x[d], 3'b001 << e.ch);
                if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
    endtask

    task automatic cyc();
        #2;
        sample(0);
        sample(1);
        @(posedge clk);
        cyc_n++;
        #1;
        mon(0);
        mon(1);
    endtask

    task automatic set_req(input int d, input int ch, input logic w, input logic [3:0] b,
                           input logic [19:0] a, input logic [31:0] x);
        vld[d][ch]        = 1'b1;
        we[d][ch]         = w;
        be[d][ch*4 +: 4]  = b;
        ad[d][ch*20 +: 20] = a;
        wd[d][ch*32 +: 32] = x;
    endtask

    task automatic wait_accept(input int d);
        int n0;
        n0 = gsize(d);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (gsize(d) != n0) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 30; i++) begin
            if (qsize(d) == 0) return;
            cyc();
        end
        chk("drain_timeout", qsize(d), 0);
    endtask

    task automatic do_access(input int d, input int ch, input logic w, input logic [3:0] b,
                             input logic [19:0] a, input logic [31:0] x);
        set_req(d, ch, w, b, a, x);
        wait_accept(d);
        vld[d][ch] = 1'b0;
        drain(d);
    endtask

    vec_t tbl [8];
    int   base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 1'b1, 4'hF, 20'h09, 32'h12345678, 32'h0};
        tbl[1] = '{1, 1'b0, 4'hF, 20'h09, 32'h0,        32'h12345678};
        tbl[2] = '{1, 1'b1, 4'h8, 20'h09, 32'hFF000000, 32'h0};
        tbl[3] = '{0, 1'b0, 4'hF, 20'h09, 32'h0,        32'hFF345678};
        tbl[4] = '{1, 1'b1, 4'h1, 20'h09, 32'h000000AB, 32'h0};
        tbl[5] = '{0, 1'b0, 4'hF, 20'h09, 32'h0,        32'hFF3456AB};
        tbl[6] = '{1, 1'b1, 4'hF, 20'h0A, 32'h0F0F0F0F, 32'h0};
        tbl[7] = '{1, 1'b0, 4'hF, 20'h0A, 32'h0,        32'h0F0F0F0F};

        rst = 2'b11;
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; we[d] = '0; be[d] = '0; ad[d] = '0; wd[d] = '0;
            next_ok[d] = 0; last_g[d] = nch(d) - 1; last_rd[d] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", rdy_a, 0);
        chk("rst_resp_valid", rv_a, 0);
        chk("rst_rdata", rd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_strobes", {ce_a, oe_a, wen_a}, 3'b111);
        chk("rst_be_n", ben_a, 4'hF);
        chk("rst_addr", addr_a, 0);
        chk("rst_data_o", do_a, 0);
        chk("rst_data_oe", doe_a, 0);
        chk("rst_b_strobes", {ce_b, oe_b, wen_b, busy_b}, 4'b1110);
        rst = 2'b00;

        // Single read of ch0 with strobe timing (WAIT_CYCLES=1).
        do_access(0, 0, 1'b1, 4'hF, 20'h00010, 32'hDEADBEEF);
        set_req(0, 0, 1'b0, 4'hF, 20'h00010, 32'h0);
        wait_accept(0);
        vld[0] = '0;
        chk("rd_t1_strobes", {ce_a, oe_a, wen_a, doe_a}, 4'b0010);
        chk("rd_t1_addr", addr_a, 20'h00010);
        chk("rd_t1_busy", busy_a, 1);
        cyc();
        chk("rd_t2_strobes", {ce_a, oe_a}, 2'b00);
        cyc();
        chk("rd_t3_resp", rv_a, 2'b01);
        chk("rd_t3_rdata", rd_a, 32'hDEADBEEF);
        chk("rd_t3_strobes", {ce_a, oe_a, wen_a}, 3'b111);
        cyc();
        chk("rd_t4_idle", {busy_a, rv_a}, 3'b000);

        // Byte-enable write on ch1 over a full word, then readback.
        do_access(0, 1, 1'b1, 4'hF, 20'h5, 32'hAAAAAAAA);
        set_req(0, 1, 1'b1, 4'b0101, 20'h5, 32'h11223344);
        wait_accept(0);
        vld[0] = '0;
        chk("be_t1_be_n", ben_a, 4'b1010);
        chk("be_t1_strobes", {ce_a, oe_a, wen_a, doe_a}, 4'b0101);
        chk("be_t1_data", do_a, 32'h11223344);
        cyc();
        chk("be_t2_we_n", wen_a, 0);
        cyc();
        chk("be_done_strobes", {ce_a, wen_a, doe_a}, 3'b111);
        chk("be_done_resp", rv_a, 2'b10);
        cyc();
        chk("be_idle_oe", doe_a, 0);
        do_access(0, 1, 1'b0, 4'hF, 20'h5, 32'h0);
        chk("be_readback", last_rd[0], 32'hAA22AA44);

        for (int i = 0; i < 8; i++) begin
            do_access(0, tbl[i].ch, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].we) chk("tbl_read", last_rd[0], tbl[i].exp_rd);
        end

        // Fixed priority: ch0 keeps winning while both are valid.
        base = gla.size();
        set_req(0, 0, 1'b0, 4'hF, 20'h00010, 32'h0);
        set_req(0, 1, 1'b0, 4'hF, 20'h5, 32'h0);
        for (int k = 0; k < 3; k++) wait_accept(0);
        vld[0][0] = 1'b0;
        wait_accept(0);
        vld[0] = '0;
        drain(0);
        chk("prio_count", gla.size() - base, 4);
        for (int k = 0; k < 4; k++) chk("prio_grant", gla[base + k], (k < 3) ? 0 : 1);

        // Reset during the second ACCESS cycle of a write.
        set_req(0, 1, 1'b1, 4'hF, 20'h20, 32'h77777777);
        wait_accept(0);
        vld[0] = '0;
        cyc();
        chk("mid_we_before", {ce_a, wen_a}, 2'b00);
        rst[0] = 1'b1;
        #1;
        chk("mid_strobes_async", {ce_a, oe_a, wen_a, doe_a}, 4'b1110);
        chk("mid_busy", busy_a, 0);
        qa.delete();
        next_ok[0] = 0;
        last_g[0]  = 1;
        cyc();
        chk("mid_no_resp", rv_a, 0);
        cyc();
        rst[0] = 1'b0;
        base = gla.size();
        set_req(0, 0, 1'b0, 4'hF, 20'h00010, 32'h0);
        set_req(0, 1, 1'b0, 4'hF, 20'h5, 32'h0);
        wait_accept(0);
        vld[0] = '0;
        chk("mid_first_grant", (gla.size() > base) ? gla[base] : -1, 0);
        drain(0);

        // Round-robin on B with all three channels valid.
        base = glb.size();
        for (int c = 0; c < 3; c++) set_req(1, c, 1'b1, 4'hF, 20'h40 + 20'(c), 32'hC0DE0000 + 32'(c));
        for (int k = 0; k < 6; k++) wait_accept(1);
        vld[1] = '0;
        drain(1);
        chk("rr_count", glb.size() - base, 6);
        for (int k = 0; k < 6; k++) chk("rr_grant", glb[base + k], k % 3);

        // Held request with WAIT_CYCLES=0; address changes right after the first accept.
        set_req(1, 1, 1'b0, 4'hF, 20'h41, 32'h0);
        wait_accept(1);
        chk("held_addr1", addr_b, 20'h41);
        ad[1][20 +: 20] = 20'h42;
        wait_accept(1);
        vld[1] = '0;
        chk("held_addr2", addr_b, 20'h42);
        chk("held_spacing", acb[acb.size()-1] - acb[acb.size()-2], 3);
        drain(1);
        chk("held_rdata", last_rd[1], 32'hC0DE0002);

        cyc();
        chk("sb_empty_a", qa.size(), 0);
        chk("sb_empty_b", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
